// File: rtl/imem_loader_pkg.sv
// Shared constants for the instruction-memory loader: FSM encodings and word geometry.
package imem_loader_pkg;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_RECV   = 2'd1;
   localparam logic [1:0] ST_WRITE  = 2'd2;
   localparam logic [1:0] ST_FINISH = 2'd3;

   localparam int BYTES_PER_WORD = 4;
   localparam int BYTE_IDX_W     = $clog2(BYTES_PER_WORD);
   localparam int WORD_W         = 8 * BYTES_PER_WORD;

endpackage

// File: rtl/word_assembler.sv
// Packs little-endian bytes into a word; exposes the word including the byte being accepted now.
module word_assembler
   import imem_loader_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              accept,
   input  logic [7:0]        byte_data,
   output logic [WORD_W-1:0] word,
   output logic              word_done
);

   localparam logic [BYTE_IDX_W-1:0] LAST_IDX = BYTE_IDX_W'(BYTES_PER_WORD - 1);

   logic [BYTE_IDX_W-1:0] idx_r;
   logic [WORD_W-1:0]     lanes_r;
   logic [WORD_W-1:0]     merged_s;

   // lane write of the incoming byte at the current byte index
   always_comb begin
      merged_s = lanes_r;
      merged_s[{idx_r, 3'b000} +: 8] = byte_data;
   end

   assign word      = merged_s;
   assign word_done = accept && (idx_r == LAST_IDX);

   // byte index and partial word; stalls hold state, the index wraps after the last lane
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx_r   <= {BYTE_IDX_W{1'b0}};
         lanes_r <= {WORD_W{1'b0}};
      end else if (clear) begin
         idx_r   <= {BYTE_IDX_W{1'b0}};
         lanes_r <= {WORD_W{1'b0}};
      end else if (accept) begin
         idx_r   <= idx_r + BYTE_IDX_W'(1);
         lanes_r <= merged_s;
      end
   end

endmodule

// File: rtl/imem_loader.sv
// Streams program bytes into instruction memory one word at a time, holding the core in reset meanwhile.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int ADDR_WIDTH = 8
)
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [ADDR_WIDTH:0]   word_count,
   input  logic                  byte_valid,
   input  logic [7:0]            byte_data,
   output logic                  byte_ready,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [31:0]           mem_wdata,
   output logic                  cpu_rst,
   output logic                  busy,
   output logic                  done,
   output logic                  err
);

   localparam logic [ADDR_WIDTH:0] DEPTH_C = {1'b1, {ADDR_WIDTH{1'b0}}};
   localparam logic [ADDR_WIDTH:0] ZERO_C  = {(ADDR_WIDTH+1){1'b0}};

   logic [1:0]            state_r, state_next_s;
   logic [ADDR_WIDTH:0]   count_r;
   logic [ADDR_WIDTH-1:0] mem_addr_r;
   logic [31:0]           mem_wdata_r;
   logic                  byte_ready_r, mem_we_r, busy_r, done_r, err_r;
   logic                  load_s, err_s, addr_inc_s, last_word_s, accept_s, word_done_s;
   logic [WORD_W-1:0]     assembled_s;

   assign accept_s    = byte_valid && byte_ready_r;
   // address is at most DEPTH-1, so the +1 fits in the wider count width and never wraps
   assign last_word_s = (({1'b0, mem_addr_r} + (ADDR_WIDTH+1)'(1)) == count_r);

   word_assembler u_asm (
      .clk       (clk),
      .rst       (rst),
      .clear     (load_s),
      .accept    (accept_s),
      .byte_data (byte_data),
      .word      (assembled_s),
      .word_done (word_done_s)
   );

   // next-state and command decode
   always_comb begin
      state_next_s = state_r;
      load_s       = 1'b0;
      err_s        = 1'b0;
      addr_inc_s   = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               if (word_count == ZERO_C) begin
                  state_next_s = ST_FINISH;
               end else if (word_count > DEPTH_C) begin
                  err_s = 1'b1;
               end else begin
                  load_s       = 1'b1;
                  state_next_s = ST_RECV;
               end
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_RECV: begin
            if (word_done_s) begin
               state_next_s = ST_WRITE;
            end else begin
               state_next_s = ST_RECV;
            end
         end
         ST_WRITE: begin
            if (last_word_s) begin
               state_next_s = ST_FINISH;
            end else begin
               state_next_s = ST_RECV;
               addr_inc_s   = 1'b1;
            end
         end
         ST_FINISH: state_next_s = ST_IDLE;
         default:   state_next_s = ST_IDLE;
      endcase
   end

   // state, registered outputs decoded from the next state, address and write data
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r      <= ST_IDLE;
         count_r      <= ZERO_C;
         mem_addr_r   <= {ADDR_WIDTH{1'b0}};
         mem_wdata_r  <= 32'h0000_0000;
         byte_ready_r <= 1'b0;
         mem_we_r     <= 1'b0;
         busy_r       <= 1'b0;
         done_r       <= 1'b0;
         err_r        <= 1'b0;
      end else begin
         state_r      <= state_next_s;
         byte_ready_r <= (state_next_s == ST_RECV);
         mem_we_r     <= (state_next_s == ST_WRITE);
         busy_r       <= (state_next_s != ST_IDLE);
         done_r       <= (state_next_s == ST_FINISH);
         err_r        <= err_s;
         if (load_s) begin
            count_r    <= word_count;
            mem_addr_r <= {ADDR_WIDTH{1'b0}};
         end else if (addr_inc_s) begin
            mem_addr_r <= mem_addr_r + ADDR_WIDTH'(1);
         end
         if (word_done_s) begin
            mem_wdata_r <= assembled_s;
         end
      end
   end

   assign byte_ready = byte_ready_r;
   assign mem_we     = mem_we_r;
   assign mem_addr   = mem_addr_r;
   assign mem_wdata  = mem_wdata_r;
   assign busy       = busy_r;
   assign done       = done_r;
   assign err        = err_r;
   assign cpu_rst    = rst || busy_r;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader (ADDR_WIDTH=2): directed loads with random bytes and valid gaps.
module tb_imem_loader;

   localparam int AW = 2;

   logic          clk = 1'b0;
   logic          rst, start, byte_valid;
   logic [AW:0]   word_count;
   logic [7:0]    byte_data;
   logic          byte_ready, mem_we, cpu_rst, busy, done, err;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wdata;

   int          errors = 0;
   int          checks = 0;
   logic [31:0] last_wr;

   imem_loader #(.ADDR_WIDTH(AW)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .word_count (word_count),
      .byte_valid (byte_valid),
      .byte_data  (byte_data),
      .byte_ready (byte_ready),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .cpu_rst    (cpu_rst),
      .busy       (busy),
      .done       (done),
      .err        (err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One complete load; expected handshake/write timing is derived from the byte stream itself.
   task automatic run_load(input int n, input int mode, input bit inject,
                           input bit use_fixed, input logic [31:0] fixed);
      logic [7:0]  bq[$];
      logic [31:0] exp_word;
      int          sent, writes, cyc;
      bit          exp_we, exp_done, exp_ready, nwe, ndone, nready, v, finished;
      for (int i = 0; i < 4*n; i++) begin
         if (use_fixed) bq.push_back(fixed[8*(i%4) +: 8]);
         else           bq.push_back(8'($urandom_range(0, 255)));
      end
      start = 1'b1; word_count = (AW+1)'(n); byte_valid = 1'b0;
      tick();
      start = 1'b0; word_count = (AW+1)'($urandom_range(0, 7));
      sent = 0; writes = 0; cyc = 0; finished = 1'b0;
      exp_we = 1'b0; exp_done = (n == 0); exp_ready = (n != 0);
      while (!finished && cyc < 200) begin
         chk("mem_we", mem_we, exp_we);
         chk("done", done, exp_done);
         chk("byte_ready", byte_ready, exp_ready);
         chk("busy", busy, 1);
         chk("cpu_rst", cpu_rst, 1);
         chk("err", err, 0);
         if (exp_we) begin
            exp_word = {bq[4*writes+3], bq[4*writes+2], bq[4*writes+1], bq[4*writes]};
            chk("mem_addr", mem_addr, writes);
            chk("mem_wdata", mem_wdata, exp_word);
            last_wr = exp_word;
            writes++;
         end else begin
            chk("wdata_hold", mem_wdata, last_wr);
         end
         if (exp_done) begin
            finished = 1'b1;
         end else begin
            nwe = 1'b0; ndone = 1'b0; nready = exp_ready;
            if (exp_we) begin
               if (writes == n) begin ndone = 1'b1; nready = 1'b0; end
               else nready = 1'b1;
            end
            start     = inject && (cyc == 2);
            byte_data = 8'($urandom_range(0, 255));
            if (exp_ready) begin
               case (mode)
                  0:       v = 1'b1;
                  1:       v = (cyc % 2 == 0);
                  default: v = 1'($urandom_range(0, 1));
               endcase
               byte_valid = v;
               if (v) begin
                  byte_data = bq[sent];
                  sent++;
                  if (sent % 4 == 0) begin nwe = 1'b1; nready = 1'b0; end
               end
            end else begin
               byte_valid = 1'($urandom_range(0, 1));
            end
            tick();
            cyc++;
            exp_we = nwe; exp_done = ndone; exp_ready = nready;
         end
      end
      chk("done_seen", finished, 1);
      start = 1'b0; byte_valid = 1'b0;
      tick();
      chk("post_busy", busy, 0);
      chk("post_cpu_rst", cpu_rst, 0);
      chk("post_done", done, 0);
      chk("post_we", mem_we, 0);
      chk("post_ready", byte_ready, 0);
      chk("writes", writes, n);
      if (n > 0) chk("addr_final", mem_addr, n - 1);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
      word_count = '0; last_wr = 32'h0;
      #1;
      chk("rst_we", mem_we, 0);
      chk("rst_addr", mem_addr, 0);
      chk("rst_wdata", mem_wdata, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_ready", byte_ready, 0);
      chk("rst_cpu_rst", cpu_rst, 1);
      tick(); tick();
      rst = 1'b0;
      tick();
      chk("idle_cpu_rst", cpu_rst, 0);
      chk("idle_busy", busy, 0);

      run_load(1, 0, 1'b0, 1'b1, 32'h0050_0013);
      run_load(3, 1, 1'b0, 1'b0, 32'h0);
      run_load(4, 2, 1'b0, 1'b0, 32'h0);

      for (int wc = 5; wc <= 7; wc += 2) begin
         start = 1'b1; word_count = (AW+1)'(wc);
         tick();
         start = 1'b0;
         chk("err_pulse", err, 1);
         chk("err_busy", busy, 0);
         chk("err_ready", byte_ready, 0);
         chk("err_done", done, 0);
         chk("err_cpu_rst", cpu_rst, 0);
         tick();
         chk("err_clear", err, 0);
         chk("err_busy2", busy, 0);
      end

      run_load(0, 0, 1'b0, 1'b0, 32'h0);

      // abort mid-word: two bytes in, then asynchronous reset between edges
      start = 1'b1; word_count = 3'd2;
      tick();
      start = 1'b0; byte_valid = 1'b1; byte_data = 8'hAA;
      tick();
      byte_data = 8'hBB;
      tick();
      byte_valid = 1'b0;
      chk("abort_ready", byte_ready, 1);
      #2 rst = 1'b1;
      #1;
      chk("abort_busy", busy, 0);
      chk("abort_ready0", byte_ready, 0);
      chk("abort_cpu_rst", cpu_rst, 1);
      chk("abort_addr", mem_addr, 0);
      chk("abort_wdata", mem_wdata, 0);
      chk("abort_we", mem_we, 0);
      tick();
      rst = 1'b0; byte_valid = 1'b1;
      tick(); tick();
      chk("no_resume_busy", busy, 0);
      chk("no_resume_ready", byte_ready, 0);
      chk("no_resume_cpu_rst", cpu_rst, 0);
      byte_valid = 1'b0; last_wr = 32'h0;
      run_load(1, 0, 1'b0, 1'b0, 32'h0);

      run_load(3, 0, 1'b1, 1'b0, 32'h0);
      for (int k = 0; k < 3; k++) begin
         run_load($urandom_range(0, 4), 2, 1'($urandom_range(0, 1)), 1'b0, 32'h0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
